// File: rtl/alu_pkg.sv
// Shared opcode, decode-bit and binary32 constants for the tinyalu datapath.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_RSV = 3'b010,
    OP_MUL = 3'b011,
    OP_LT  = 3'b100,
    OP_EQ  = 3'b101,
    OP_LE  = 3'b110,
    OP_DIV = 3'b111
  } alu_op_e;

  localparam int          FLOAT_BIT  = 3;
  localparam int          SIGNED_BIT = 4;
  localparam logic [31:0] QNAN       = 32'h7FC0_0000;
  localparam int          FP_BIAS    = 127;

endpackage

// File: rtl/alu_if.sv
// Operand/instruction/result bundle between the datapath driver and alu_core.
interface alu_if #(
  parameter int WIDTH = 32
) ();
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [31:0]      instruction;
  logic [WIDTH-1:0] s;
  logic             ze;

  modport master (output a, b, instruction, input s, ze);
  modport slave  (input a, b, instruction, output s, ze);
endinterface

// File: rtl/alu_fpu.sv
// Combinational binary32 add/sub/mul/div/compare, round-to-nearest-even,
// subnormal inputs and results flushed to signed zero.
module alu_fpu
  import alu_pkg::*;
(
  input  alu_op_e     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  localparam logic signed [9:0] BIAS = 10'(FP_BIAS);

  // m[26] is the leading one, m[2:0] are guard/round/sticky.
  function automatic logic [31:0] round_pack(input logic sign, input logic signed [9:0] exp,
                                             input logic [26:0] m);
    logic              up;
    logic [24:0]       mant;
    logic signed [9:0] e;
    up   = m[2] & (m[1] | m[0] | m[3]);
    mant = {1'b0, m[26:3]} + {24'd0, up};
    e    = exp;
    if (mant[24]) begin
      mant = mant >> 1;
      e    = e + 10'sd1;
    end
    if (e >= 10'sd255)    round_pack = {sign, 8'hFF, 23'd0};
    else if (e <= 10'sd0) round_pack = {sign, 31'd0};
    else                  round_pack = {sign, e[7:0], mant[22:0]};
  endfunction

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    lzc27 = 5'd27;
    for (int i = 0; i < 27; i++)
      if (v[i]) lzc27 = 5'(26 - i);
  endfunction

  logic        sa, sb, za, zb, ia, ib, na, nb;
  logic [7:0]  ea, eb;
  logic [23:0] ma, mb;

  assign sa = a[31];
  assign sb = b[31];
  assign ea = a[30:23];
  assign eb = b[30:23];
  assign ma = {1'b1, a[22:0]};
  assign mb = {1'b1, b[22:0]};
  assign za = (ea == 8'd0);
  assign zb = (eb == 8'd0);
  assign ia = (ea == 8'hFF) && (a[22:0] == 23'd0);
  assign ib = (eb == 8'hFF) && (b[22:0] == 23'd0);
  assign na = (ea == 8'hFF) && (a[22:0] != 23'd0);
  assign nb = (eb == 8'hFF) && (b[22:0] != 23'd0);

  logic        sb_eff, swap, s_big, s_small;
  logic [7:0]  e_big, e_small, d;
  logic [23:0] m_big, m_small;
  logic [4:0]  d_sh, lz;
  logic [49:0] sh;
  logic [26:0] big27, small27, diff27, norm27;
  logic [27:0] sum28;
  logic [31:0] add_y;

  always_comb begin
    sb_eff = sb ^ (op == OP_SUB);
    swap   = {eb, b[22:0]} > {ea, a[22:0]};
    if (swap) begin
      s_big = sb_eff; e_big = eb; m_big = mb;
      s_small = sa;   e_small = ea; m_small = ma;
    end else begin
      s_big = sa;       e_big = ea; m_big = ma;
      s_small = sb_eff; e_small = eb; m_small = mb;
    end
    // Beyond 26 places the small operand only contributes sticky.
    d       = e_big - e_small;
    d_sh    = (d > 8'd31) ? 5'd31 : d[4:0];
    sh      = {m_small, 26'd0} >> d_sh;
    small27 = {sh[49:24], sh[23] | (|sh[22:0])};
    big27   = {m_big, 3'b000};
    sum28   = {1'b0, big27} + {1'b0, small27};
    diff27  = big27 - small27;
    lz      = lzc27(diff27);
    norm27  = diff27 << lz;

    if (na | nb)                       add_y = QNAN;
    else if (ia & ib & (sa != sb_eff)) add_y = QNAN;
    else if (ia)                       add_y = {sa, 8'hFF, 23'd0};
    else if (ib)                       add_y = {sb_eff, 8'hFF, 23'd0};
    else if (za & zb)                  add_y = 32'd0;
    else if (za)                       add_y = {sb_eff, b[30:0]};
    else if (zb)                       add_y = a;
    else if (s_big == s_small) begin
      if (sum28[27])
        add_y = round_pack(s_big, $signed({2'b00, e_big}) + 10'sd1,
                           {sum28[27:2], sum28[1] | sum28[0]});
      else
        add_y = round_pack(s_big, $signed({2'b00, e_big}), sum28[26:0]);
    end
    else if (diff27 == 27'd0)          add_y = 32'd0;
    else add_y = round_pack(s_big, $signed({2'b00, e_big}) - $signed({5'd0, lz}), norm27);
  end

  logic              sxy;
  logic [47:0]       prod;
  logic signed [9:0] mul_e, div_e;
  logic [49:0]       dvd, quo, rem;
  logic [26:0]       q27;
  logic [31:0]       mul_y, div_y;
  logic              unused_quo;

  assign sxy        = sa ^ sb;
  assign prod       = {24'd0, ma} * {24'd0, mb};
  assign mul_e      = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
  assign dvd        = {ma, 26'd0};
  assign quo        = dvd / {26'd0, mb};
  assign rem        = dvd % {26'd0, mb};
  assign q27        = quo[26:0];
  assign div_e      = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS;
  assign unused_quo = |quo[49:27];

  always_comb begin
    if (na | nb)                        mul_y = QNAN;
    else if ((ia & zb) | (za & ib))     mul_y = QNAN;
    else if (ia | ib)                   mul_y = {sxy, 8'hFF, 23'd0};
    else if (za | zb)                   mul_y = {sxy, 31'd0};
    else if (prod[47]) mul_y = round_pack(sxy, mul_e + 10'sd1, {prod[47:22], |prod[21:0]});
    else               mul_y = round_pack(sxy, mul_e, {prod[46:21], |prod[20:0]});

    // Quotient of two 1.x mantissas lies in (0.5, 2): one normalising step at most.
    if (na | nb)                        div_y = QNAN;
    else if ((ia & ib) | (za & zb))     div_y = QNAN;
    else if (ia | zb)                   div_y = {sxy, 8'hFF, 23'd0};
    else if (ib | za)                   div_y = {sxy, 31'd0};
    else if (q27[26]) div_y = round_pack(sxy, div_e, {q27[26:1], q27[0] | (|rem)});
    else              div_y = round_pack(sxy, div_e - 10'sd1, {q27[25:0], |rem});
  end

  logic [31:0] ca, cb, ka, kb;
  logic        unord, f_lt, f_eq;

  always_comb begin
    ca    = za ? 32'd0 : a;
    cb    = zb ? 32'd0 : b;
    ka    = ca[31] ? ~ca : {1'b1, ca[30:0]};
    kb    = cb[31] ? ~cb : {1'b1, cb[30:0]};
    unord = na | nb;
    f_lt  = ~unord & (ka < kb);
    f_eq  = ~unord & (ca == cb);
    case (op)
      OP_ADD, OP_SUB: y = add_y;
      OP_MUL:         y = mul_y;
      OP_DIV:         y = div_y;
      OP_LT:          y = {31'd0, f_lt};
      OP_EQ:          y = {31'd0, f_eq};
      OP_LE:          y = {31'd0, f_lt | f_eq};
      default:        y = 32'd0;
    endcase
  end

endmodule

// File: rtl/alu_core.sv
// tinyalu datapath: instruction decode, integer path, float sub-unit and the
// single output register stage holding result and zero flag.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic rst_n,
  alu_if.slave bus
);
  localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  alu_op_e                 op;
  logic                    is_float, is_signed, lt_int, eq_int;
  logic [WIDTH-1:0]        a, b, int_y, fpu_y, s_nxt;
  logic signed [WIDTH-1:0] a_s, b_s;
  logic [WIDTH-1:0]        s_p1;
  logic                    ze_p1;
  logic                    unused_instr;

  assign op           = alu_op_e'(bus.instruction[2:0]);
  assign is_float     = bus.instruction[FLOAT_BIT];
  assign is_signed    = bus.instruction[SIGNED_BIT];
  assign unused_instr = ^bus.instruction[31:5];
  assign a            = bus.a;
  assign b            = bus.b;
  assign a_s          = bus.a;
  assign b_s          = bus.b;
  assign lt_int       = is_signed ? (a_s < b_s) : (a < b);
  assign eq_int       = (a == b);

  always_comb begin
    int_y = '0;
    case (op)
      OP_ADD: int_y = a + b;
      OP_SUB: int_y = a - b;
      OP_MUL: int_y = a * b;
      OP_DIV: begin
        // The signed MIN/-1 quotient is not representable; it wraps to MIN.
        if (b == '0)                                  int_y = '1;
        else if (is_signed && a == INT_MIN && b == '1) int_y = INT_MIN;
        else if (is_signed)                           int_y = a_s / b_s;
        else                                          int_y = a / b;
      end
      OP_LT:   int_y = {{(WIDTH-1){1'b0}}, lt_int};
      OP_EQ:   int_y = {{(WIDTH-1){1'b0}}, eq_int};
      OP_LE:   int_y = {{(WIDTH-1){1'b0}}, lt_int | eq_int};
      default: int_y = '0;
    endcase
  end

  alu_fpu u_fpu (
    .op (op),
    .a  (a),
    .b  (b),
    .y  (fpu_y)
  );

  assign s_nxt = is_float ? fpu_y : int_y;

  // Stage p1: registered result and zero flag taken from the same next value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_p1  <= '0;
      ze_p1 <= 1'b1;
    end else begin
      s_p1  <= s_nxt;
      ze_p1 <= (s_nxt == '0);
    end
  end

  assign bus.s  = s_p1;
  assign bus.ze = ze_p1;

endmodule

// File: tb/tb_alu_core.sv
// Scoreboard bench for alu_core: expected results queued at drive time and
// compared one clock edge later.
module tb_alu_core;
  logic clk = 1'b0;
  logic rst_n;

  alu_if bus ();

  alu_core dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_assert++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask

  task automatic drive_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] instr,
                          input logic [31:0] want, input string tag);
    bus.a = a;
    bus.b = b;
    bus.instruction = instr;
    exp_q.push_back(want);
    tag_q.push_back(tag);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] instr,
                       input logic [31:0] want, input string tag);
    @(negedge clk);
    drive_op(a, b, instr, want, tag);
  endtask

  // Reference integer model on 64-bit values; truncation gives the 32-bit wrap.
  function automatic logic [31:0] int_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [4:0] ins);
    longint      x, y;
    logic [63:0] r;
    x = ins[4] ? longint'($signed(a)) : longint'({32'd0, a});
    y = ins[4] ? longint'($signed(b)) : longint'({32'd0, b});
    case (ins[2:0])
      3'b000:  r = 64'(x + y);
      3'b001:  r = 64'(x - y);
      3'b011:  r = 64'(x * y);
      3'b111:  r = (y == 0) ? 64'h0000_0000_FFFF_FFFF : 64'(x / y);
      3'b100:  r = {63'd0, x < y};
      3'b101:  r = {63'd0, x == y};
      3'b110:  r = {63'd0, x <= y};
      default: r = 64'd0;
    endcase
    return r[31:0];
  endfunction

  always @(posedge clk) begin
    logic [31:0] e;
    string       t;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_val(t, bus.s, e);
      check_val({t, ".ze"}, {31'd0, bus.ze}, {31'd0, e == 32'd0});
    end
  end

  localparam logic [4:0]  SOP  [7] = '{5'b10000, 5'b10001, 5'b10011, 5'b10111,
                                       5'b10110, 5'b10100, 5'b10101};
  localparam logic [31:0] SEXP [7] = '{32'hFFFFFFF9, 32'hFFFFFFFD, 32'h0000000A, 32'h00000002,
                                       32'h1, 32'h1, 32'h0};

  // 3.2f is 0x404CCCCD; 3.2f - 1.3f is exact and lands on 0x3FF33334.
  localparam int NF = 26;
  localparam logic [31:0] FA [NF] = '{
    32'h404CCCCD, 32'h404CCCCD, 32'h404CCCCD, 32'h404CCCCD, 32'h404CCCCD, 32'h404CCCCD,
    32'h404CCCCD, 32'hBFA66666, 32'h7F800000, 32'h3F800000, 32'h80000000, 32'h3F800000,
    32'h7F7FFFFF, 32'h7F800001, 32'h00000000, 32'h00000000, 32'h00800000, 32'h7FC00000,
    32'h3F800000, 32'h3FC00000, 32'hFF800000, 32'h00000001, 32'h40400000, 32'h3F800000,
    32'h3F800000, 32'hBF800000};
  localparam logic [31:0] FB [NF] = '{
    32'hBFA66666, 32'hBFA66666, 32'hBFA66666, 32'hBFA66666, 32'hBFA66666, 32'hBFA66666,
    32'hBFA66666, 32'h404CCCCD, 32'h7F800000, 32'h00000000, 32'h00000000, 32'hBF800000,
    32'h7F7FFFFF, 32'h3F800000, 32'hFF800000, 32'h00000000, 32'h3F000000, 32'h3F800000,
    32'h3F800000, 32'h40000000, 32'h3F800000, 32'h80000000, 32'h3F800000, 32'h40400000,
    32'h3F800000, 32'h3F800000};
  localparam logic [4:0] FI [NF] = '{
    5'b01000, 5'b01001, 5'b01011, 5'b01111, 5'b01100, 5'b01101,
    5'b11110, 5'b11100, 5'b01001, 5'b01111, 5'b01101, 5'b01000,
    5'b01000, 5'b01000, 5'b01011, 5'b01111, 5'b01011, 5'b01100,
    5'b01110, 5'b01011, 5'b01000, 5'b01101, 5'b01111, 5'b01111,
    5'b01001, 5'b01010};
  localparam logic [31:0] FE [NF] = '{
    32'h3FF33334, 32'h40900000, 32'hC0851EB8, 32'hC01D89D9, 32'h00000000, 32'h00000000,
    32'h00000000, 32'h00000001, 32'h7FC00000, 32'h7F800000, 32'h00000001, 32'h00000000,
    32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'h00000000, 32'h00000000,
    32'h00000001, 32'h40400000, 32'hFF800000, 32'h00000001, 32'h40400000, 32'h3EAAAAAB,
    32'h00000000, 32'h00000000};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb, ri, rr;
    logic [2:0]  rop;
    int          k;

    bus.a = '0;
    bus.b = '0;
    bus.instruction = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check_val("rst.s", bus.s, 32'd0);
    check_val("rst.ze", {31'd0, bus.ze}, 32'd1);
    bus.a = 32'd5;
    bus.b = 32'd3;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_hold.s", bus.s, 32'd0);
    check_val("rst_hold.ze", {31'd0, bus.ze}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    drive_op(32'd5, 32'd3, 32'h0, 32'd8, "first_add");

    for (int i = 0; i < 7; i++)
      issue(32'hFFFFFFFB, 32'hFFFFFFFE, {27'd0, SOP[i]}, SEXP[i], $sformatf("sint.%0d", i));

    issue(32'hFFFFFFFB, 32'hFFFFFFFE, 32'h04, 32'h1, "ult");
    issue(32'h00000007, 32'h00000000, 32'h17, 32'hFFFFFFFF, "sdiv0");
    issue(32'h00000007, 32'h00000000, 32'h07, 32'hFFFFFFFF, "udiv0");
    issue(32'h80000000, 32'hFFFFFFFF, 32'h17, 32'h80000000, "sdiv_ovf");
    issue(32'h80000000, 32'hFFFFFFFF, 32'h07, 32'h00000000, "udiv_big");
    issue(32'hFFFFFFF9, 32'h00000002, 32'h17, 32'hFFFFFFFD, "sdiv_trunc");
    issue(32'hFFFFFFFF, 32'h00000001, 32'h00, 32'h00000000, "add_wrap");
    issue(32'h00000009, 32'h00000004, 32'h02, 32'h00000000, "int_rsv");
    issue(32'h00000009, 32'h00000004, 32'hFFFFFFE1, 32'h00000005, "hi_bits_ignored");

    for (int i = 0; i < NF; i++)
      issue(FA[i], FB[i], {27'd0, FI[i]}, FE[i], $sformatf("flt.%0d", i));

    issue(32'hFFFFFFFB, 32'hFFFFFFFE, 32'h10, 32'hFFFFFFF9, "pre_rst");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_val("midrst.s", bus.s, 32'd0);
    check_val("midrst.ze", {31'd0, bus.ze}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    drive_op(32'd5, 32'd3, 32'h0, 32'd8, "post_rst_add");

    for (int i = 0; i < 48; i++) begin
      rr = $urandom;
      if (i % 4 == 3) begin
        k = $urandom_range(0, NF - 1);
        issue(FA[k], FB[k], {rr[31:5], FI[k]}, FE[k], $sformatf("b2b.%0d.f%0d", i, k));
      end else begin
        rop = 3'($urandom_range(0, 7));
        ra  = (i % 3 == 0) ? $urandom : 32'($urandom_range(0, 40)) - 32'd20;
        if (i % 11 == 4) ra = 32'h80000000;
        case (i % 8)
          1:       rb = 32'd0;
          5:       rb = 32'hFFFFFFFF;
          2, 6:    rb = $urandom;
          default: rb = 32'($urandom_range(0, 16)) - 32'd8;
        endcase
        ri = {rr[31:5], rr[4], 1'b0, rop};
        issue(ra, rb, ri, int_model(ra, rb, ri[4:0]), $sformatf("b2b.%0d.i%0h", i, ri[4:0]));
      end
    end

    @(posedge clk);
    #2;
    check_val("sb.drain", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
